seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the watch display. It shares one two-digit BCD-to-seven-segment decoder between three digit pairs: hours, minutes and seconds. Each frame it snapshots the three BCD bytes, then steps through the pairs. For each pair it presents one byte to the decoder and drives a one-hot pair-enable with anti-ghosting dead time. It also blanks the field being edited at a slow blink rate. It sits between the timekeeping counters and the shared decoder/digit drivers.

---
 rtl/seg7_scan_pkg.sv | 36 +++
 rtl/seg7_scan_ctrl_counter.sv | 44 ++++
 rtl/seg7_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the slot encoding, the edit-field codes presented by the
// setting logic, and the bit positions of each pair in pair_en.
package seg7_scan_pkg;

  // Display slot, also the scan state; value 3 is never entered.
  typedef enum logic [1:0] {
    S_HRS = 2'd0,
    S_MIN = 2'd1,
    S_SEC = 2'd2
  } slot_e;

  // Field currently being edited (the one that blinks).
  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_HRS  = 2'd1;
  localparam logic [1:0] EDIT_MIN  = 2'd2;
  localparam logic [1:0] EDIT_SEC  = 2'd3;

  // Bit positions inside pair_en.
  localparam int PAIR_HRS = 0;
  localparam int PAIR_MIN = 1;
  localparam int PAIR_SEC = 2;

  // Edit code that selects a given slot for blinking.
  function automatic logic [1:0] editCodeFor(input slot_e s);
    logic [1:0] code;
    case (s)
      S_HRS:   code = EDIT_HRS;
      S_MIN:   code = EDIT_MIN;
      S_SEC:   code = EDIT_SEC;
      default: code = EDIT_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_counter.sv
// Modulo-MOD up counter with enable, used for the dwell timer and the
// blink frame counter.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the count
//   en   - advance by one on this clock
//   cnt  - current count, 0..MOD-1
//   wrap - high on the enabled clock where cnt = MOD-1 (count returns to 0)
module mod_counter #(
  parameter int MOD = 2,
  localparam int W = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: hold, step, or return to zero after the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = en && (cnt_q == LAST);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexing scan controller for the watch display. Snapshots the
// hours/minutes/seconds BCD bytes once per frame and steps one shared
// two-digit decoder through the three pairs, with a dead time at the start
// of every slot and a slow blink on the field being edited.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   hours_bcd    - packed BCD hours   ([7:4] tens, [3:0] ones)
//   mins_bcd     - packed BCD minutes
//   secs_bcd     - packed BCD seconds
//   edit_field   - field to blink: 0 none, 1 hours, 2 minutes, 3 seconds
//   blank        - force all pair enables off
//   bcd_out      - byte for the shared decoder (current slot's snapshot)
//   pair_en      - one-hot pair enable: bit0 hours, bit1 minutes, bit2 seconds
//   frame_start  - high in the first cycle of each hours slot
module seg7_scan_ctrl
  import seg7_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEAD         = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hours_bcd,
  input  logic [7:0] mins_bcd,
  input  logic [7:0] secs_bcd,
  input  logic [1:0] edit_field,
  input  logic       blank,
  output logic [7:0] bcd_out,
  output logic [2:0] pair_en,
  output logic       frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  slot_e      state_q, state_d;
  logic [7:0] snapH_q, snapM_q, snapS_q;
  logic       blinkPh_q;
  logic       blankR_q;
  logic [1:0] editR_q;

  logic [CW-1:0] dwellCnt;
  logic          dwellWrap;
  logic [BW-1:0] blinkCnt;
  logic          blinkWrap;
  logic          frameWrap;
  logic          slotOn;

  // Dwell timer: free-running, wraps exactly at each slot change.
  mod_counter #(.MOD(SCAN_DIV)) uDwell (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .cnt  (dwellCnt),
    .wrap (dwellWrap)
  );

  // The last cycle of the seconds slot closes the frame.
  assign frameWrap = dwellWrap && (state_q == S_SEC);

  // Blink frame counter; its wrap marks the end of a blink half-period.
  mod_counter #(.MOD(BLINK_FRAMES)) uBlink (
    .clk  (clk),
    .rst  (rst),
    .en   (frameWrap),
    .cnt  (blinkCnt),
    .wrap (blinkWrap)
  );

  // Only the wrap pulse of the blink counter matters here.
  logic unusedBlinkCnt;
  assign unusedBlinkCnt = ^blinkCnt;

  // Slot sequence hours -> minutes -> seconds -> hours.
  always_comb begin
    state_d = state_q;
    if (dwellWrap) begin
      case (state_q)
        S_HRS:   state_d = S_MIN;
        S_MIN:   state_d = S_SEC;
        default: state_d = S_HRS;
      endcase
    end
  end

  // Scan state, frame snapshot, blink phase and registered controls.
  // The snapshot only loads on the frame wrap so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HRS;
      snapH_q   <= 8'h00;
      snapM_q   <= 8'h00;
      snapS_q   <= 8'h00;
      blinkPh_q <= 1'b0;
      blankR_q  <= 1'b0;
      editR_q   <= EDIT_NONE;
    end else begin
      state_q  <= state_d;
      blankR_q <= blank;
      editR_q  <= edit_field;
      if (frameWrap) begin
        snapH_q <= hours_bcd;
        snapM_q <= mins_bcd;
        snapS_q <= secs_bcd;
      end
      if (blinkWrap) begin
        blinkPh_q <= ~blinkPh_q;
      end
    end
  end

  // Enable is off during the dead time, while blanked, and while the
  // edited field is in the dark half of the blink.
  assign slotOn = (dwellCnt >= CW'(DEAD)) && !blankR_q &&
                  !(blinkPh_q && (editR_q == editCodeFor(state_q)));

  // Moore output decode from registers only.
  always_comb begin
    bcd_out     = 8'h00;
    pair_en     = 3'b000;
    frame_start = (state_q == S_HRS) && (dwellCnt == '0);
    case (state_q)
      S_HRS: begin
        bcd_out           = snapH_q;
        pair_en[PAIR_HRS] = slotOn;
      end
      S_MIN: begin
        bcd_out           = snapM_q;
        pair_en[PAIR_MIN] = slotOn;
      end
      S_SEC: begin
        bcd_out           = snapS_q;
        pair_en[PAIR_SEC] = slotOn;
      end
      default: begin
        bcd_out = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a short scan (8 clocks per
// slot, 2 dead clocks, 2 frames per blink half-period). Expected outputs
// come from a cycle-index model: slot, position and blink phase are
// derived arithmetically from the number of cycles since reset.
module tb_seg7_scan_ctrl;

  localparam int SD    = 8;
  localparam int DT    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 3 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hours_bcd = 8'h00;
  logic [7:0] mins_bcd = 8'h00;
  logic [7:0] secs_bcd = 8'h00;
  logic [1:0] edit_field = 2'd0;
  logic       blank = 1'b0;
  logic [7:0] bcd_out;
  logic [2:0] pair_en;
  logic       frame_start;

  int nChecks = 0;
  int nFails  = 0;

  seg7_scan_ctrl #(.SCAN_DIV(SD), .DEAD(DT), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .hours_bcd   (hours_bcd),
    .mins_bcd    (mins_bcd),
    .secs_bcd    (secs_bcd),
    .edit_field  (edit_field),
    .blank       (blank),
    .bcd_out     (bcd_out),
    .pair_en     (pair_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model state: cycles since reset, the bytes captured at the
  // start of the current frame, and the previous cycle's blank/edit.
  int         mT;
  logic [7:0] mSnap [3];
  logic       mBlankR;
  logic [1:0] mEditR;

  // Model update: a new frame begins every FRAME cycles and captures
  // whatever the inputs were on the edge that starts it.
  always @(posedge clk) begin
    if (rst) begin
      mT       <= 0;
      mSnap[0] <= 8'h00;
      mSnap[1] <= 8'h00;
      mSnap[2] <= 8'h00;
      mBlankR  <= 1'b0;
      mEditR   <= 2'd0;
    end else begin
      mT <= mT + 1;
      if ((mT + 1) % FRAME == 0) begin
        mSnap[0] <= hours_bcd;
        mSnap[1] <= mins_bcd;
        mSnap[2] <= secs_bcd;
      end
      mBlankR <= blank;
      mEditR  <= edit_field;
    end
  end

  // Expected {bcd_out, pair_en, frame_start} for the current cycle.
  function automatic logic [11:0] modelOut();
    int         slot, pos, ph;
    logic       on;
    logic [2:0] pe;
    logic       fs;
    slot = (mT / SD) % 3;
    pos  = mT % SD;
    ph   = ((mT / FRAME) / BF) % 2;
    on   = (pos >= DT) && !mBlankR && !(ph == 1 && int'(mEditR) == slot + 1);
    pe   = on ? 3'(1 << slot) : 3'b000;
    fs   = (mT % FRAME == 0) ? 1'b1 : 1'b0;
    return {mSnap[slot], pe, fs};
  endfunction

  function automatic logic [7:0] randBcd();
    return {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
  endfunction

  // Reset state, then the first frame's enable layout.
  task automatic test_reset();
    logic [11:0] exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nChecks++;
    if ({bcd_out, pair_en, frame_start} !== 12'b0000_0000_000_1) begin
      nFails++;
      $display("[TB] FAIL reset_state got=%h required=%h",
               {bcd_out, pair_en, frame_start}, 12'b0000_0000_000_1);
    end
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      exp = modelOut();
      nChecks++;
      if ({bcd_out, pair_en, frame_start} !== exp) begin
        nFails++;
        $display("[TB] FAIL reset_frame t=%0d got=%h required=%h",
                 mT, {bcd_out, pair_en, frame_start}, exp);
      end
      if (c == 2 || c == 10 || c == 18) begin
        nChecks++;
        if (pair_en !== 3'(1 << (c / SD))) begin
          nFails++;
          $display("[TB] FAIL reset_layout t=%0d got=%b required=%b",
                   c, pair_en, 3'(1 << (c / SD)));
        end
      end
    end
  endtask

  // Inputs driven mid-frame 1 appear only from frame 2.
  task automatic test_snapshot();
    logic [11:0] exp;
    logic [7:0]  want;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      exp = modelOut();
      nChecks++;
      if ({bcd_out, pair_en, frame_start} !== exp) begin
        nFails++;
        $display("[TB] FAIL snapshot t=%0d got=%h required=%h",
                 mT, {bcd_out, pair_en, frame_start}, exp);
      end
      if (mT >= FRAME && mT < 3 * FRAME) begin
        want = (mT < 2 * FRAME) ? 8'h00 :
               ((mT / SD) % 3 == 0) ? 8'h12 :
               ((mT / SD) % 3 == 1) ? 8'h34 : 8'h56;
        nChecks++;
        if (bcd_out !== want) begin
          nFails++;
          $display("[TB] FAIL snapshot_value t=%0d got=%h required=%h",
                   mT, bcd_out, want);
        end
      end
      if (mT == FRAME + 6) begin
        hours_bcd = 8'h12;
        mins_bcd  = 8'h34;
        secs_bcd  = 8'h56;
      end
    end
  endtask

  // A minutes change during the minutes slot waits for the next frame.
  task automatic test_midframe_change();
    logic [11:0] exp;
    int          frameBase;
    frameBase = ((mT / FRAME) + 1) * FRAME;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      exp = modelOut();
      nChecks++;
      if ({bcd_out, pair_en, frame_start} !== exp) begin
        nFails++;
        $display("[TB] FAIL midframe t=%0d got=%h required=%h",
                 mT, {bcd_out, pair_en, frame_start}, exp);
      end
      if (mT >= frameBase + SD && mT < frameBase + 2 * SD) begin
        nChecks++;
        if (bcd_out !== 8'h34) begin
          nFails++;
          $display("[TB] FAIL midframe_hold t=%0d got=%h required=%h",
                   mT, bcd_out, 8'h34);
        end
      end
      if (mT >= frameBase + FRAME + SD && mT < frameBase + FRAME + 2 * SD) begin
        nChecks++;
        if (bcd_out !== 8'h35) begin
          nFails++;
          $display("[TB] FAIL midframe_next t=%0d got=%h required=%h",
                   mT, bcd_out, 8'h35);
        end
      end
      if (mT == frameBase + SD + 2) mins_bcd = 8'h35;
    end
  endtask

  // Minutes blink: dark in frames 2-3, lit in 0-1 and 4-5.
  task automatic test_blink();
    logic [11:0] exp;
    logic        want;
    rst = 1'b1;
    edit_field = 2'd2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6 * FRAME; c++) begin
      if (c > 0) @(negedge clk);
      exp = modelOut();
      nChecks++;
      if ({bcd_out, pair_en, frame_start} !== exp) begin
        nFails++;
        $display("[TB] FAIL blink t=%0d got=%h required=%h",
                 mT, {bcd_out, pair_en, frame_start}, exp);
      end
      if (mT % SD >= DT) begin
        want = ((mT / SD) % 3 == 1) ? !(mT / FRAME == 2 || mT / FRAME == 3) : 1'b1;
        nChecks++;
        if ((pair_en != 3'b000) !== want) begin
          nFails++;
          $display("[TB] FAIL blink_enable t=%0d got=%b required_lit=%b",
                   mT, pair_en, want);
        end
      end
      hours_bcd = randBcd();
      mins_bcd  = randBcd();
      secs_bcd  = randBcd();
    end
  endtask

  // Blank at slot cycle 5 takes effect at 6; release resumes one cycle later.
  task automatic test_blank();
    logic [11:0] exp;
    int          base;
    edit_field = 2'd0;
    base = ((mT / FRAME) + 1) * FRAME;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      exp = modelOut();
      nChecks++;
      if ({bcd_out, pair_en, frame_start} !== exp) begin
        nFails++;
        $display("[TB] FAIL blank t=%0d got=%h required=%h",
                 mT, {bcd_out, pair_en, frame_start}, exp);
      end
      if (mT == base + 6 || mT == base + 12) begin
        nChecks++;
        if (pair_en !== 3'b000) begin
          nFails++;
          $display("[TB] FAIL blank_off t=%0d got=%b required=%b", mT, pair_en, 3'b000);
        end
      end
      if (mT == base + 13) begin
        nChecks++;
        if (pair_en !== 3'b010) begin
          nFails++;
          $display("[TB] FAIL blank_resume t=%0d got=%b required=%b", mT, pair_en, 3'b010);
        end
      end
      if (mT == base + 5) blank = 1'b1;
      if (mT == base + 12) blank = 1'b0;
    end
  endtask

  // Reset during seconds slot cycle 4 restarts the frame immediately.
  task automatic test_reset_mid();
    logic [11:0] exp;
    int          budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (mT % FRAME != 2 * SD + 4 && budget < 3 * FRAME);
    nChecks++;
    if (mT % FRAME != 2 * SD + 4) begin
      nFails++;
      $display("[TB] FAIL reset_mid_wait got_pos=%0d required_pos=%0d",
               mT % FRAME, 2 * SD + 4);
    end
    rst = 1'b1;
    hours_bcd = randBcd();
    @(negedge clk);
    rst = 1'b0;
    nChecks++;
    if ({bcd_out, pair_en, frame_start} !== 12'b0000_0000_000_1) begin
      nFails++;
      $display("[TB] FAIL reset_mid_state got=%h required=%h",
               {bcd_out, pair_en, frame_start}, 12'b0000_0000_000_1);
    end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      exp = modelOut();
      nChecks++;
      if ({bcd_out, pair_en, frame_start} !== exp || (mT < FRAME && bcd_out !== 8'h00)) begin
        nFails++;
        $display("[TB] FAIL reset_mid_frame t=%0d got=%h required=%h",
                 mT, {bcd_out, pair_en, frame_start}, exp);
      end
    end
  endtask

  // Random inputs, blanking and edit re-targeting against the model.
  task automatic test_random();
    logic [11:0] exp;
    for (int c = 0; c < 10 * FRAME; c++) begin
      @(negedge clk);
      exp = modelOut();
      nChecks++;
      if ({bcd_out, pair_en, frame_start} !== exp) begin
        nFails++;
        $display("[TB] FAIL random t=%0d got=%h required=%h",
                 mT, {bcd_out, pair_en, frame_start}, exp);
      end
      if ($urandom_range(3, 0) == 0) hours_bcd = randBcd();
      if ($urandom_range(3, 0) == 0) mins_bcd  = randBcd();
      if ($urandom_range(3, 0) == 0) secs_bcd  = randBcd();
      if ($urandom_range(15, 0) == 0) edit_field = 2'($urandom_range(3, 0));
      if ($urandom_range(19, 0) == 0) blank = ~blank;
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_midframe_change();
    test_blink();
    test_blank();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
